// File: rtl/dac_spi_pkg.sv
// Shared types and sizing helpers for the DAC SPI transmit path.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int OVR_W = 16;

  function automatic int frame_w(input int cmd_w, input int dac_w);
    return cmd_w + dac_w;
  endfunction

endpackage

// File: rtl/dac_fmt.sv
// Round-half-up, arithmetic shift, saturate to DAC width, optional offset-binary MSB flip.
module dac_fmt #(
  parameter int IN_W       = 32,
  parameter int DAC_W      = 16,
  parameter int SHIFT      = 0,
  parameter int OFFSET_BIN = 0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic        [DAC_W-1:0] word,
  output logic                    clip
);

  // One extra bit so the rounding add can never wrap.
  localparam logic signed [IN_W:0] RND  = ((IN_W+1)'(1) << SHIFT) >> 1;
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((longint'(1) << (DAC_W-1)) - 1);
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shifted;

  always_comb begin
    sum     = $signed({din[IN_W-1], din}) + RND;
    shifted = sum >>> SHIFT;
    clip    = 1'b0;
    word    = shifted[DAC_W-1:0];
    if (shifted > MAXV) begin
      clip = 1'b1;
      word = MAXV[DAC_W-1:0];
    end else if (shifted < MINV) begin
      clip = 1'b1;
      word = MINV[DAC_W-1:0];
    end
    if (OFFSET_BIN != 0) word[DAC_W-1] = ~word[DAC_W-1];
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Formats filtered samples into a one-entry hold buffer and ships them as SPI
// write frames (command byte + data word), CPOL=0, MSB first.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int               IN_W       = 32,
  parameter int               DAC_W      = 16,
  parameter int               SHIFT      = 0,
  parameter int               OFFSET_BIN = 0,
  parameter int               CMD_W      = 8,
  parameter logic [CMD_W-1:0] CMD        = 8'h30,
  parameter int               CLK_DIV    = 4,
  parameter int               GAP_HP     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   sclk,
  output logic                   mosi,
  output logic                   cs_n,
  output logic                   sat,
  output logic [OVR_W-1:0]       overrun_cnt
);

  localparam int FRAME_W = frame_w(CMD_W, DAC_W);
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int GAP_CW  = $clog2(GAP_HP) + 1;

  logic [DAC_W-1:0]   fmt_word;
  logic               fmt_clip;
  logic [DAC_W-1:0]   hold_reg;
  logic               hold_full_reg;
  state_t             state_reg;
  logic [FRAME_W-1:0] shreg_reg;
  logic [DIV_W-1:0]   div_reg;
  logic [BIT_W-1:0]   bit_reg;
  logic [GAP_CW-1:0]  gap_reg;
  logic               sclk_reg, mosi_reg, cs_n_reg, sat_reg;
  logic [OVR_W-1:0]   ovr_reg;
  logic               tick, gap_done, drain;

  dac_fmt #(
    .IN_W(IN_W), .DAC_W(DAC_W), .SHIFT(SHIFT), .OFFSET_BIN(OFFSET_BIN)
  ) u_fmt (
    .din(s_data), .word(fmt_word), .clip(fmt_clip)
  );

  // A back-to-back load straight out of GAP keeps cs_n high for exactly GAP_HP half-periods.
  always_comb begin
    tick     = (div_reg == DIV_W'(CLK_DIV - 1));
    gap_done = (state_reg == ST_GAP) && tick && (gap_reg == GAP_CW'(GAP_HP - 1));
    drain    = hold_full_reg && ((state_reg == ST_IDLE) || gap_done);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      state_reg     <= ST_IDLE;
      shreg_reg     <= '0;
      div_reg       <= '0;
      bit_reg       <= '0;
      gap_reg       <= '0;
      sclk_reg      <= 1'b0;
      mosi_reg      <= 1'b0;
      cs_n_reg      <= 1'b1;
      sat_reg       <= 1'b0;
      ovr_reg       <= '0;
    end else begin
      sat_reg <= s_valid && fmt_clip;
      if (s_valid) begin
        hold_reg      <= fmt_word;
        hold_full_reg <= 1'b1;
        if (hold_full_reg && !drain && (ovr_reg != '1))
          ovr_reg <= ovr_reg + 1'b1;
      end else if (drain) begin
        hold_full_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (hold_full_reg) begin
            shreg_reg <= {CMD, hold_reg};
            mosi_reg  <= CMD[CMD_W-1];
            cs_n_reg  <= 1'b0;
            sclk_reg  <= 1'b0;
            div_reg   <= '0;
            bit_reg   <= '0;
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          div_reg <= tick ? '0 : div_reg + 1'b1;
          if (tick) begin
            if (!sclk_reg) begin
              sclk_reg <= 1'b1;
            end else begin
              sclk_reg <= 1'b0;
              if (bit_reg == BIT_W'(FRAME_W - 1)) begin
                cs_n_reg  <= 1'b1;
                mosi_reg  <= 1'b0;
                div_reg   <= '0;
                gap_reg   <= '0;
                state_reg <= ST_GAP;
              end else begin
                shreg_reg <= shreg_reg << 1;
                mosi_reg  <= shreg_reg[FRAME_W-2];
                bit_reg   <= bit_reg + 1'b1;
              end
            end
          end
        end
        ST_GAP: begin
          div_reg <= tick ? '0 : div_reg + 1'b1;
          if (gap_done) begin
            if (hold_full_reg) begin
              shreg_reg <= {CMD, hold_reg};
              mosi_reg  <= CMD[CMD_W-1];
              cs_n_reg  <= 1'b0;
              div_reg   <= '0;
              bit_reg   <= '0;
              state_reg <= ST_SHIFT;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else if (tick) begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign s_ready     = ~hold_full_reg;
  assign sclk        = sclk_reg;
  assign mosi        = mosi_reg;
  assign cs_n        = cs_n_reg;
  assign sat         = sat_reg;
  assign overrun_cnt = ovr_reg;

endmodule
